// File: rtl/mac_spike_scheduler.sv
// mac_spike_scheduler: round-robin arbitration of spike requests into a FIFO,
// paced presentation of buffered addresses to the MAC, and per-timestep
// set / clear / capture sequencing.
module mac_spike_scheduler #(
    parameter int                NUM_PORTS   = 4,
    parameter int                ADDR_W      = 12,
    parameter int                FIFO_DEPTH  = 8,
    parameter int                TS_CYCLES   = 16,
    parameter int                INIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] NULL_ADDR   = 12'hFFF
) (
    input  logic                        CLK_Mac,
    input  logic                        RST_N,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic                        mac_set,
    output logic                        mac_clear,
    output logic [ADDR_W-1:0]           mac_source_address,
    input  logic [31:0]                 mac_result,
    output logic [31:0]                 result,
    output logic                        result_valid,
    output logic [15:0]                 timestep_count
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = FW + 1;
    localparam int TW = (TS_CYCLES > 1) ? $clog2(TS_CYCLES) : 1;
    localparam int IW = $clog2(INIT_CYCLES + 1);

    localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_PORTS - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TS_LAST    = TW'(TS_CYCLES - 1);
    localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYCLES);

    typedef enum logic [2:0] {
        S_INIT, S_COLLECT, S_DRAIN, S_CLEAR, S_CAPTURE
    } state_t;

    state_t            state, state_next;
    logic [IW-1:0]     init_cnt;
    logic [TW-1:0]     ts_cnt;
    logic [PW-1:0]     rr_ptr;
    logic [ADDR_W-1:0] port_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant;
    logic [PW-1:0]     grant_idx;
    logic [PW:0]       cand_sum;
    logic [ADDR_W-1:0] grant_addr;
    logic              grant_allowed;
    logic              presenting;
    logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [ADDR_W-1:0] addr_reg;
    logic              show_reg;
    logic [31:0]       result_reg;
    logic              result_valid_reg;
    logic [15:0]       ts_count_reg;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign port_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign grant_addr = port_addr[grant_idx];
    // A NULL_ADDR request is granted but never enters the buffer.
    assign push = (grant != '0) && (grant_addr != NULL_ADDR);
    // Pop only after a NULL slot so that each address forms a distinct MAC event.
    assign pop  = presenting && !show_reg && !fifo_empty;

    assign req_ready          = grant;
    assign mac_source_address = addr_reg;
    assign result             = result_reg;
    assign result_valid       = result_valid_reg;
    assign timestep_count     = ts_count_reg;

    // State register.
    always_ff @(posedge CLK_Mac or negedge RST_N) begin
        if (!RST_N) state <= S_INIT;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_INIT:    if (init_cnt == INIT_LAST) state_next = S_COLLECT;
            S_COLLECT: if (ts_cnt == TS_LAST) state_next = S_DRAIN;
            S_DRAIN:   if (fifo_empty && !show_reg) state_next = S_CLEAR;
            S_CLEAR:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_COLLECT;
            default:   state_next = S_INIT;
        endcase
    end

    // State-decoded outputs and enables; mac_set stays low in the first INIT cycle after reset.
    always_comb begin
        mac_set       = (state == S_INIT) && (init_cnt != '0);
        mac_clear     = (state == S_CLEAR);
        grant_allowed = (state == S_COLLECT) && !fifo_full;
        presenting    = (state == S_COLLECT) || (state == S_DRAIN);
    end

    // Round-robin pick: lowest rotation offset from rr_ptr with a valid request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand_sum  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand_sum >= (PW+1)'(NUM_PORTS)) cand_sum = cand_sum - (PW+1)'(NUM_PORTS);
            if (req_valid[cand_sum[PW-1:0]]) grant_idx = cand_sum[PW-1:0];
        end
        if (grant_allowed && (req_valid != '0)) grant[grant_idx] = 1'b1;
    end

    // INIT strobe counter and COLLECT cycle counter.
    always_ff @(posedge CLK_Mac or negedge RST_N) begin
        if (!RST_N) begin
            init_cnt <= '0;
            ts_cnt   <= '0;
        end else begin
            if ((state == S_INIT) && (init_cnt != INIT_LAST)) init_cnt <= init_cnt + 1'b1;
            if (state == S_COLLECT) ts_cnt <= (ts_cnt == TS_LAST) ? '0 : ts_cnt + 1'b1;
            else                    ts_cnt <= '0;
        end
    end

    // Round-robin pointer moves to the port after the one just granted.
    always_ff @(posedge CLK_Mac or negedge RST_N) begin
        if (!RST_N)            rr_ptr <= '0;
        else if (grant != '0)  rr_ptr <= (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge CLK_Mac or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage array, no reset so it maps onto block RAM.
    always_ff @(posedge CLK_Mac) begin
        if (push) fifo_mem[wr_ptr] <= grant_addr;
    end

    // Presentation register: popped address for one cycle, otherwise NULL_ADDR.
    always_ff @(posedge CLK_Mac or negedge RST_N) begin
        if (!RST_N) begin
            addr_reg <= NULL_ADDR;
            show_reg <= 1'b0;
        end else if (pop) begin
            addr_reg <= fifo_mem[rd_ptr];
            show_reg <= 1'b1;
        end else begin
            addr_reg <= NULL_ADDR;
            show_reg <= 1'b0;
        end
    end

    // Capture of the MAC sum at the end of each timestep.
    always_ff @(posedge CLK_Mac or negedge RST_N) begin
        if (!RST_N) begin
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            ts_count_reg     <= '0;
        end else begin
            result_valid_reg <= (state == S_CAPTURE);
            if (state == S_CAPTURE) begin
                result_reg   <= mac_result;
                ts_count_reg <= ts_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mac_spike_scheduler.sv
// Directed testbench for mac_spike_scheduler (4 ports, 8-deep FIFO, 16-cycle COLLECT).
`timescale 1ns/1ps
module tb_mac_spike_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid;
    logic [47:0] req_addr;
    logic [3:0]  req_ready;
    logic        mac_set;
    logic        mac_clear;
    logic [11:0] mac_source_address;
    logic [31:0] mac_result;
    logic [31:0] result;
    logic        result_valid;
    logic [15:0] timestep_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    // Grant order expected in the full-FIFO timestep (pointer starts at port 2).
    int          order [4]   = '{2, 3, 0, 1};
    logic [11:0] exp_seq [15] = '{12'h00A, 12'h00C, 12'h008, 12'h009,
                                  12'h00A, 12'h00C, 12'h008, 12'h009,
                                  12'h00A, 12'h00C, 12'h008, 12'h009,
                                  12'h00A, 12'h00C, 12'h008};
    logic [11:0] seen [$];

    mac_spike_scheduler #(
        .NUM_PORTS(4), .ADDR_W(12), .FIFO_DEPTH(8),
        .TS_CYCLES(16), .INIT_CYCLES(2), .NULL_ADDR(12'hFFF)
    ) dut (
        .CLK_Mac(clk),
        .RST_N(rst_n),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .mac_set(mac_set),
        .mac_clear(mac_clear),
        .mac_source_address(mac_source_address),
        .mac_result(mac_result),
        .result(result),
        .result_valid(result_valid),
        .timestep_count(timestep_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [11:0] a);
        req_addr[p*12 +: 12] = a;
    endtask

    // One COLLECT cycle: drive valids, check grant, clock, check the next presented address.
    task automatic cyc(input logic [3:0] v, input logic [3:0] exp_ready,
                       input logic [11:0] exp_addr, input string tag);
        req_valid = v;
        #1;
        check({tag, "/ready"}, 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        check({tag, "/addr"}, 32'(mac_source_address), 32'(exp_addr));
        $display("[TB] %s: ready=%b addr=%h", tag, exp_ready, mac_source_address);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t reached limit without finishing", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid  = 4'h0;
        req_addr   = '0;
        mac_result = 32'h0;
        set_addr(0, 12'h008);
        set_addr(1, 12'h009);
        set_addr(2, 12'h00A);
        set_addr(3, 12'h00C);
        req_valid = 4'hF;
        tick();
        tick();
        check("rst/mac_set", 32'(mac_set), 32'd0);
        check("rst/mac_clear", 32'(mac_clear), 32'd0);
        check("rst/req_ready", 32'(req_ready), 32'd0);
        check("rst/addr", 32'(mac_source_address), 32'hFFF);
        check("rst/result", result, 32'd0);
        check("rst/result_valid", 32'(result_valid), 32'd0);
        check("rst/ts_count", 32'(timestep_count), 32'd0);
        req_valid = 4'h0;

        // INIT: mac_set high in cycles 1-2 after release, low from cycle 3.
        rst_n = 1'b1;
        tick(); check("init/c1", 32'(mac_set), 32'd1);
        tick(); check("init/c2", 32'(mac_set), 32'd1);
        tick(); check("init/c3", 32'(mac_set), 32'd0);
        $display("[TB] init sequence done");

        // All four ports valid: grants 0,1,2,3, addresses 8,FFF,9,FFF,A,FFF,C,FFF.
        cyc(4'hF, 4'b0001, 12'hFFF, "rr/ts0");
        cyc(4'hE, 4'b0010, 12'h008, "rr/ts1");
        cyc(4'hC, 4'b0100, 12'hFFF, "rr/ts2");
        cyc(4'h8, 4'b1000, 12'h009, "rr/ts3");
        cyc(4'h0, 4'b0000, 12'hFFF, "rr/ts4");
        cyc(4'h0, 4'b0000, 12'h00A, "rr/ts5");
        cyc(4'h0, 4'b0000, 12'hFFF, "rr/ts6");
        cyc(4'h0, 4'b0000, 12'h00C, "rr/ts7");
        cyc(4'h0, 4'b0000, 12'hFFF, "rr/ts8");

        // Port 1 sends address 9 twice back to back: 9,FFF,9,FFF.
        cyc(4'h2, 4'b0010, 12'hFFF, "dup/ts9");
        cyc(4'h2, 4'b0010, 12'h009, "dup/ts10");
        cyc(4'h0, 4'b0000, 12'hFFF, "dup/ts11");
        cyc(4'h0, 4'b0000, 12'h009, "dup/ts12");
        cyc(4'h0, 4'b0000, 12'hFFF, "dup/ts13");
        cyc(4'h0, 4'b0000, 12'hFFF, "dup/ts14");
        cyc(4'h0, 4'b0000, 12'hFFF, "dup/ts15");

        // DRAIN with empty FIFO, then CLEAR, CAPTURE.
        check("drain/clear_low", 32'(mac_clear), 32'd0);
        mac_result = 32'h430D07AF;
        req_valid  = 4'hF;
        #1;
        check("drain/ready_blocked", 32'(req_ready), 32'd0);
        req_valid = 4'h0;
        tick();
        check("clear/strobe", 32'(mac_clear), 32'd1);
        check("clear/addr", 32'(mac_source_address), 32'hFFF);
        tick();
        check("capture/clear_done", 32'(mac_clear), 32'd0);
        check("capture/rv_low", 32'(result_valid), 32'd0);
        tick();
        check("capture/result", result, 32'h430D07AF);
        check("capture/rv_pulse", 32'(result_valid), 32'd1);
        check("capture/ts_count", 32'(timestep_count), 32'd1);
        $display("[TB] timestep 1 captured result=%h count=%0d", result, timestep_count);

        // Hold all ports valid for the whole COLLECT phase.
        req_valid = 4'hF;
        for (int t = 0; t < 16; t++) begin
            #1;
            check("fill/ready", 32'(req_ready),
                  (t < 15) ? (32'd1 << order[t % 4]) : 32'd0);
            @(posedge clk);
            #1;
            if (t == 0) check("fill/rv_drop", 32'(result_valid), 32'd0);
            if (mac_source_address != 12'hFFF) seen.push_back(mac_source_address);
            $display("[TB] fill ts%0d: ready=%b addr=%h", t, req_ready, mac_source_address);
        end
        n = 0;
        while ((mac_clear !== 1'b1) && (n < 40)) begin
            tick();
            n++;
            if (n == 1) check("drain/ready_zero", 32'(req_ready), 32'd0);
            if (mac_source_address != 12'hFFF) seen.push_back(mac_source_address);
        end
        req_valid = 4'h0;
        check("drain/cycles_to_clear", 32'(n), 32'd16);
        check("drain/spike_count", 32'(seen.size()), 32'd15);
        for (int k = 0; k < 15; k++) begin
            if (k < seen.size()) check("drain/spike_seq", 32'(seen[k]), 32'(exp_seq[k]));
        end
        $display("[TB] full timestep: %0d spikes presented, clear after %0d drain cycles", seen.size(), n);
        mac_result = 32'h3F800000;
        tick();
        check("capture2/clear_once", 32'(mac_clear), 32'd0);
        tick();
        check("capture2/result", result, 32'h3F800000);
        check("capture2/rv_pulse", 32'(result_valid), 32'd1);
        check("capture2/ts_count", 32'(timestep_count), 32'd2);

        // Fill again, then reset during DRAIN with 5 entries buffered.
        req_valid = 4'hF;
        repeat (16) tick();
        repeat (4) tick();
        check("rst2/busy_addr", 32'(mac_source_address != 12'hFFF), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst2/addr", 32'(mac_source_address), 32'hFFF);
        check("rst2/req_ready", 32'(req_ready), 32'd0);
        check("rst2/mac_set", 32'(mac_set), 32'd0);
        check("rst2/mac_clear", 32'(mac_clear), 32'd0);
        check("rst2/result", result, 32'd0);
        check("rst2/result_valid", 32'(result_valid), 32'd0);
        check("rst2/ts_count", 32'(timestep_count), 32'd0);
        $display("[TB] reset asserted in DRAIN: addr=%h count=%0d", mac_source_address, timestep_count);
        req_valid = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
        tick(); check("init2/c1", 32'(mac_set), 32'd1);
        tick(); check("init2/c2", 32'(mac_set), 32'd1);
        tick(); check("init2/c3", 32'(mac_set), 32'd0);

        // NULL_ADDR request is granted but discarded; no stale spikes after reset.
        set_addr(0, 12'hFFF);
        set_addr(3, 12'h005);
        cyc(4'h1, 4'b0001, 12'hFFF, "post/null_grant");
        cyc(4'h8, 4'b1000, 12'hFFF, "post/ts1");
        cyc(4'h0, 4'b0000, 12'h005, "post/ts2");
        cyc(4'h0, 4'b0000, 12'hFFF, "post/ts3");
        cyc(4'h0, 4'b0000, 12'hFFF, "post/ts4");
        cyc(4'h0, 4'b0000, 12'hFFF, "post/ts5");
        cyc(4'h0, 4'b0000, 12'hFFF, "post/ts6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_spike_scheduler.md
MAC_SPIKE_SCHEDULER -- requirements
Module: mac_spike_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of spike requesters.
REQ-002 SHALL have parameter ADDR_W, default 12, source address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, spike buffer entries, power of two.
REQ-004 SHALL have parameter TS_CYCLES, default 16, COLLECT-phase length in cycles per timestep.
REQ-005 SHALL have parameter INIT_CYCLES, default 2, mac_set pulse length after reset.
REQ-006 SHALL have parameter NULL_ADDR, default 12'hFFF, idle value driven on mac_source_address.
REQ-007 SHALL have port CLK_Mac, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port RST_N, input, 1, reset, asynchronous assert, active-low.
REQ-009 SHALL have port req_valid, input, NUM_PORTS, per-port spike request.
REQ-010 SHALL have port req_addr, input, NUM_PORTS*ADDR_W, per-port source address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-011 SHALL have port req_ready, output, NUM_PORTS, grant; transfer when valid and ready are both high at a clock edge.
REQ-012 SHALL have port mac_set, output, 1, MAC weight/address initialisation strobe.
REQ-013 SHALL have port mac_clear, output, 1, MAC end-of-timestep strobe.
REQ-014 SHALL have port mac_source_address, output, ADDR_W, spike address presented to the MAC.
REQ-015 SHALL have port mac_result, input, 32, MAC float32 weighted sum.
REQ-016 SHALL have port result, output, 32, captured weighted sum for the last timestep.
REQ-017 SHALL have port result_valid, output, 1, one-cycle pulse when result updates.
REQ-018 SHALL have port timestep_count, output, 16, completed timesteps, wraps at 16'hFFFF to 0.

Function
REQ-019 SHALL implement FSM states INIT, COLLECT, DRAIN, CLEAR, CAPTURE; INIT is the reset state.
REQ-020 INIT: mac_set=1 for exactly INIT_CYCLES cycles, req_ready=0, then go to COLLECT with mac_set=0.
REQ-021 COLLECT: cycle counter runs 0..TS_CYCLES-1; at TS_CYCLES-1, go to DRAIN.
REQ-022 COLLECT: one grant per cycle at most; round-robin among valid ports, starting after the last granted port; pointer resets to port 0.
REQ-023 req_ready SHALL be one-hot or zero; zero when FIFO full, or state is not COLLECT.
REQ-024 Granted address SHALL be pushed to the FIFO; address equal to NULL_ADDR SHALL be accepted and discarded.
REQ-025 Presentation: FIFO head is popped and driven on mac_source_address for 1 cycle, then NULL_ADDR for 1 cycle; max one spike per 2 cycles, so repeated addresses produce distinct MAC events.
REQ-026 Presentation SHALL run in COLLECT and DRAIN; simultaneous push and pop in the same cycle SHALL keep the FIFO count unchanged.
REQ-027 When no spike is being presented, mac_source_address SHALL equal NULL_ADDR.
REQ-028 DRAIN: req_ready=0; leave to CLEAR when FIFO empty and the last address's NULL_ADDR cycle is complete.
REQ-029 CLEAR: mac_clear=1 for exactly 1 cycle, mac_source_address=NULL_ADDR, then CAPTURE.
REQ-030 CAPTURE: latch mac_result into result, pulse result_valid for 1 cycle, increment timestep_count, then COLLECT with counter 0.
REQ-031 A request held with valid high and not granted SHALL stay pending; no request is lost or duplicated.
REQ-032 FIFO full and pop in the same COLLECT cycle: no grant in that cycle; grant resumes the next cycle.

Reset
REQ-033 RST_N low SHALL immediately force: state INIT, FIFO empty, counters 0, RR pointer 0, mac_set=0, mac_clear=0, req_ready=0, mac_source_address=NULL_ADDR, result=0, result_valid=0, timestep_count=0.
REQ-034 Reset mid-timestep SHALL discard buffered spikes; after release, the INIT sequence (REQ-020) SHALL repeat.

Verification
REQ-035 Release reset -> mac_set high cycles 1-2, low from cycle 3, COLLECT entered, req_ready responds to requests.
REQ-036 Ports 0..3 all valid with addrs 8,9,10,12 -> grants in order 0,1,2,3, one per cycle; mac_source_address sequence 8,FFF,9,FFF,10,FFF,12,FFF.
REQ-037 Port 1 sends addr 9 twice back-to-back -> mac_source_address 9,FFF,9,FFF (two distinct events).
REQ-038 Hold all ports valid for a full COLLECT -> FIFO reaches 8, req_ready=0 while full, no loss; DRAIN empties FIFO before the single mac_clear cycle.
REQ-039 Drive mac_result=32'h430D07AF during CAPTURE -> result=32'h430D07AF, result_valid pulses once, timestep_count increments by 1.
REQ-040 Assert RST_N low during DRAIN with 5 entries buffered -> all outputs at reset values immediately; post-release, no stale address appears on mac_source_address.
